// File: rtl/load_store_queue.sv
// load_store_queue: in-order load/store queue with CDB snooping and a single outstanding cache request; define LSQ_IO_CONFIRM_EN to hold loads to addr[17:16]==2'b11 until they reach the ROB head
module load_store_queue #(
  parameter int LSQ_SIZE_BIT = 3,
  parameter int ROB_BIT = 4,
  parameter int NUM_CDB = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     inst_valid,
  input  logic [3:0]               inst_type,
  input  logic [31:0]              inst_r1,
  input  logic [31:0]              inst_r2,
  input  logic [ROB_BIT-1:0]       inst_dep1,
  input  logic [ROB_BIT-1:0]       inst_dep2,
  input  logic                     inst_has_dep1,
  input  logic                     inst_has_dep2,
  input  logic [11:0]              inst_offset,
  input  logic [ROB_BIT-1:0]       inst_rob_id,
  output logic                     full,
  output logic                     cache_valid,
  output logic                     cache_wr,
  output logic [2:0]               cache_size,
  output logic [31:0]              cache_addr,
  output logic [31:0]              cache_value,
  input  logic                     cache_ready,
  input  logic [31:0]              cache_res,
  input  logic                     rob_empty,
  input  logic [ROB_BIT-1:0]       rob_id_head,
  input  logic [NUM_CDB-1:0]       cdb_ready,
  input  logic [NUM_CDB*ROB_BIT-1:0] cdb_rob_id,
  input  logic [NUM_CDB*32-1:0]    cdb_value,
  output logic                     lsb_ready,
  output logic [ROB_BIT-1:0]       lsb_rob_id,
  output logic [31:0]              lsb_value
);
  localparam int DEPTH = 1 << LSQ_SIZE_BIT;
  localparam logic [LSQ_SIZE_BIT:0] DEPTH_C = (LSQ_SIZE_BIT+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
  state_t state, state_nx;
  logic [LSQ_SIZE_BIT-1:0] head, tail, nh;
  logic [LSQ_SIZE_BIT:0] count, count_nx;
  logic [DEPTH-1:0] busy, p1, p2, p1_nx, p2_nx;
  logic [3:0] typ [DEPTH];
  logic [31:0] r1 [DEPTH], r2 [DEPTH], r1_nx [DEPTH], r2_nx [DEPTH];
  logic [ROB_BIT-1:0] d1 [DEPTH], d2 [DEPTH], rid [DEPTH];
  logic [11:0] off [DEPTH];
  logic push, pop, issue, st, io, push_p1, push_p2, cur_st;
  logic [31:0] addr_nx, push_r1, push_r2;
  logic [ROB_BIT-1:0] cur_rob;

  // resolve one operand against the lsb output and the CDB; lower channels override higher ones
  function automatic logic [32:0] snoop(input logic pend, input logic [ROB_BIT-1:0] tag, input logic [31:0] val);
    logic [32:0] r;
    r = {pend, val};
    if (pend && lsb_ready && lsb_rob_id == tag) r = {1'b0, lsb_value};
    for (int c = NUM_CDB-1; c >= 0; c--)
      if (pend && cdb_ready[c] && cdb_rob_id[c*ROB_BIT +: ROB_BIT] == tag) r = {1'b0, cdb_value[c*32 +: 32]};
    return r;
  endfunction

  // operand wakeup, head selection after a possible pop, and issue decision
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {p1_nx[i], r1_nx[i]} = snoop(busy[i] && p1[i], d1[i], r1[i]);
      {p2_nx[i], r2_nx[i]} = snoop(busy[i] && p2[i], d2[i], r2[i]);
    end
    {push_p1, push_r1} = snoop(inst_has_dep1, inst_dep1, inst_r1);
    {push_p2, push_r2} = snoop(inst_has_dep2, inst_dep2, inst_r2);
    push = inst_valid && count != DEPTH_C && !flush_in;
    pop = state == WAIT && cache_ready && !flush_in;
    nh = head + LSQ_SIZE_BIT'(pop);
    addr_nx = r1[nh] + {{20{off[nh][11]}}, off[nh]};
    st = typ[nh][3];
`ifdef LSQ_IO_CONFIRM_EN
    io = addr_nx[17:16] == 2'b11;
`else
    io = 1'b0;
`endif
    issue = (state == IDLE || pop) && !flush_in && busy[nh] && !p1[nh] && !p2[nh] &&
            ((st || io) ? (!rob_empty && rid[nh] == rob_id_head) : 1'b1);
    count_nx = flush_in ? '0 : count + (LSQ_SIZE_BIT+1)'(push) - (LSQ_SIZE_BIT+1)'(pop);
    state_nx = state;
    case (state)
      IDLE:    state_nx = issue ? WAIT : IDLE;
      WAIT:    state_nx = flush_in ? DRAIN : cache_ready ? (issue ? WAIT : IDLE) : WAIT;
      default: state_nx = cache_ready ? IDLE : DRAIN;
    endcase
  end

  // queue storage, pointers, cache request and completion broadcast
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      head <= '0;
      tail <= '0;
      count <= '0;
      busy <= '0;
      p1 <= '0;
      p2 <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        typ[i] <= '0;
        r1[i] <= '0;
        r2[i] <= '0;
        d1[i] <= '0;
        d2[i] <= '0;
        rid[i] <= '0;
        off[i] <= '0;
      end
      full <= 1'b0;
      cache_valid <= 1'b0;
      cache_wr <= 1'b0;
      cache_size <= '0;
      cache_addr <= '0;
      cache_value <= '0;
      cur_rob <= '0;
      cur_st <= 1'b0;
      lsb_ready <= 1'b0;
      lsb_rob_id <= '0;
      lsb_value <= '0;
    end else if (rdy_in) begin
      p1 <= p1_nx;
      p2 <= p2_nx;
      for (int i = 0; i < DEPTH; i++) begin
        r1[i] <= r1_nx[i];
        r2[i] <= r2_nx[i];
      end
      if (pop) busy[head] <= 1'b0;
      if (push) begin
        busy[tail] <= 1'b1;
        typ[tail] <= inst_type;
        r1[tail] <= push_r1;
        r2[tail] <= push_r2;
        p1[tail] <= push_p1;
        p2[tail] <= push_p2;
        d1[tail] <= inst_dep1;
        d2[tail] <= inst_dep2;
        rid[tail] <= inst_rob_id;
        off[tail] <= inst_offset;
      end
      if (flush_in) busy <= '0;
      head <= flush_in ? '0 : nh;
      tail <= flush_in ? '0 : tail + LSQ_SIZE_BIT'(push);
      count <= count_nx;
      full <= count_nx >= DEPTH_C - 1'b1;
      state <= state_nx;
      cache_valid <= state_nx != IDLE;
      lsb_ready <= pop;
      if (pop) begin
        lsb_rob_id <= cur_rob;
        lsb_value <= cur_st ? '0 : cache_res;
      end
      if (issue) begin
        cache_wr <= st;
        cache_size <= {typ[nh][2], typ[nh][1:0]};
        cache_addr <= addr_nx;
        cache_value <= r2[nh];
        cur_rob <= rid[nh];
        cur_st <= st;
      end
    end
  end
endmodule

// File: tb/tb_load_store_queue.sv
// tb_load_store_queue: directed checks of the load/store queue
module tb_load_store_queue;
  logic clk_in = 1'b0, rst_n_in, rdy_in, flush_in, inst_valid;
  logic [3:0] inst_type, inst_dep1, inst_dep2, inst_rob_id, rob_id_head, lsb_rob_id;
  logic [31:0] inst_r1, inst_r2, cache_addr, cache_value, cache_res, lsb_value;
  logic inst_has_dep1, inst_has_dep2, full, cache_valid, cache_wr, cache_ready, rob_empty, lsb_ready;
  logic [11:0] inst_offset;
  logic [2:0] cache_size;
  logic [1:0] cdb_ready;
  logic [7:0] cdb_rob_id;
  logic [63:0] cdb_value;
  int checks = 0, errors = 0;

  load_store_queue dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .inst_valid(inst_valid), .inst_type(inst_type), .inst_r1(inst_r1), .inst_r2(inst_r2),
    .inst_dep1(inst_dep1), .inst_dep2(inst_dep2), .inst_has_dep1(inst_has_dep1),
    .inst_has_dep2(inst_has_dep2), .inst_offset(inst_offset), .inst_rob_id(inst_rob_id),
    .full(full), .cache_valid(cache_valid), .cache_wr(cache_wr), .cache_size(cache_size),
    .cache_addr(cache_addr), .cache_value(cache_value), .cache_ready(cache_ready),
    .cache_res(cache_res), .rob_empty(rob_empty), .rob_id_head(rob_id_head),
    .cdb_ready(cdb_ready), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b,
                      input logic [11:0] o, input logic [3:0] rid, input logic h1, input logic [3:0] dp1);
    inst_valid = 1'b1;
    inst_type = t;
    inst_r1 = a;
    inst_r2 = b;
    inst_offset = o;
    inst_rob_id = rid;
    inst_has_dep1 = h1;
    inst_dep1 = dp1;
    tick();
    inst_valid = 1'b0;
    inst_has_dep1 = 1'b0;
  endtask

  task automatic complete(input logic [31:0] res);
    cache_ready = 1'b1;
    cache_res = res;
    tick();
    cache_ready = 1'b0;
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; inst_valid = 1'b0; inst_type = '0;
    inst_r1 = '0; inst_r2 = '0; inst_dep1 = '0; inst_dep2 = '0; inst_has_dep1 = 1'b0;
    inst_has_dep2 = 1'b0; inst_offset = '0; inst_rob_id = '0; cache_ready = 1'b0; cache_res = '0;
    rob_empty = 1'b1; rob_id_head = '0; cdb_ready = '0; cdb_rob_id = '0; cdb_value = '0;
    tick(); tick();
    chk("rst_full", full, 0);
    chk("rst_valid", cache_valid, 0);
    chk("rst_lsb_ready", lsb_ready, 0);
    chk("rst_addr", cache_addr, 0);
    chk("rst_lsb_value", lsb_value, 0);
    rst_n_in = 1'b1;
    push(4'b0010, 32'h100, 32'h0, 12'hFFC, 4'd1, 1'b0, 4'd0);
    chk("lw_not_yet", cache_valid, 0);
    tick();
    chk("lw_valid", cache_valid, 1);
    chk("lw_addr", cache_addr, 32'h0FC);
    chk("lw_size", cache_size, 2);
    chk("lw_wr", cache_wr, 0);
    tick();
    complete(32'hDEADBEEF);
    chk("lw_lsb_ready", lsb_ready, 1);
    chk("lw_lsb_rob", lsb_rob_id, 1);
    chk("lw_lsb_value", lsb_value, 32'hDEADBEEF);
    chk("lw_idle", cache_valid, 0);
    tick();
    chk("lw_lsb_pulse", lsb_ready, 0);
    rob_empty = 1'b0; rob_id_head = 4'd3;
    push(4'b1010, 32'h200, 32'h1234, 12'h008, 4'd5, 1'b0, 4'd0);
    tick(); tick();
    chk("sw_blocked", cache_valid, 0);
    rob_id_head = 4'd5;
    tick();
    chk("sw_valid", cache_valid, 1);
    chk("sw_wr", cache_wr, 1);
    chk("sw_addr", cache_addr, 32'h208);
    chk("sw_value", cache_value, 32'h1234);
    complete(32'hFFFF);
    chk("sw_lsb_rob", lsb_rob_id, 5);
    chk("sw_lsb_value", lsb_value, 0);
    tick();
    cdb_ready = 2'b10; cdb_rob_id = {4'd2, 4'd0}; cdb_value = {32'h40, 32'h0};
    push(4'b0010, 32'h0, 32'h0, 12'h010, 4'd6, 1'b1, 4'd2);
    cdb_ready = '0;
    tick();
    chk("cdb_push_valid", cache_valid, 1);
    chk("cdb_push_addr", cache_addr, 32'h50);
    push(4'b0010, 32'h0, 32'h0, 12'h000, 4'd7, 1'b1, 4'd7);
    cdb_ready = 2'b11; cdb_rob_id = {4'd7, 4'd7}; cdb_value = {32'h222, 32'h111};
    tick();
    cdb_ready = '0;
    complete(32'h55);
    chk("b2b_lsb_rob", lsb_rob_id, 6);
    chk("b2b_lsb_value", lsb_value, 32'h55);
    chk("b2b_valid", cache_valid, 1);
    chk("cdb_prio_addr", cache_addr, 32'h111);
    complete(32'h66);
    chk("b2b_second_rob", lsb_rob_id, 7);
    chk("b2b_drained", cache_valid, 0);
    tick();
    for (int i = 0; i < 7; i++) begin
      chk("fill_not_full", full, 0);
      push(4'b0010, 32'h1000, 32'h0, 12'h000, 4'(8 + i), 1'b0, 4'd0);
    end
    chk("fill_full7", full, 1);
    push(4'b0010, 32'h1000, 32'h0, 12'h000, 4'd15, 1'b0, 4'd0);
    chk("fill_count8", dut.count, 8);
    push(4'b0010, 32'h1000, 32'h0, 12'h000, 4'd0, 1'b0, 4'd0);
    chk("fill_count9_ignored", dut.count, 8);
    chk("fill_full", full, 1);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    chk("fill_flush_count", dut.count, 0);
    complete(32'h0);
    chk("fill_drain_no_lsb", lsb_ready, 0);
    rob_id_head = 4'd9;
    push(4'b1010, 32'h300, 32'h77, 12'h000, 4'd9, 1'b0, 4'd0);
    tick();
    chk("fl_valid", cache_valid, 1);
    chk("fl_wr", cache_wr, 1);
    flush_in = 1'b1;
    push(4'b0010, 32'h0, 32'h0, 12'h000, 4'd1, 1'b0, 4'd0);
    flush_in = 1'b0;
    chk("fl_count", dut.count, 0);
    chk("fl_full", full, 0);
    chk("fl_held", cache_valid, 1);
    tick();
    chk("fl_held2", cache_valid, 1);
    chk("fl_addr_stable", cache_addr, 32'h300);
    complete(32'h0);
    chk("fl_released", cache_valid, 0);
    chk("fl_no_lsb", lsb_ready, 0);
    tick();
    chk("fl_no_issue", cache_valid, 0);
    rob_id_head = 4'd0;
    push(4'b0010, 32'h30000, 32'h0, 12'h000, 4'd3, 1'b0, 4'd0);
    tick();
`ifdef LSQ_IO_CONFIRM_EN
    chk("io_wait", cache_valid, 0);
    rob_id_head = 4'd3;
    tick();
`endif
    chk("io_valid", cache_valid, 1);
    chk("io_addr", cache_addr, 32'h30000);
    complete(32'hABC);
    chk("io_lsb_rob", lsb_rob_id, 3);
    push(4'b0010, 32'h10, 32'h0, 12'h000, 4'd4, 1'b0, 4'd0);
    tick();
    chk("mid_valid", cache_valid, 1);
    rst_n_in = 1'b0;
    #1;
    chk("mid_rst_valid", cache_valid, 0);
    chk("mid_rst_addr", cache_addr, 0);
    tick();
    rst_n_in = 1'b1;
    complete(32'h9);
    chk("mid_ignore_ready", lsb_ready, 0);
    chk("mid_idle", cache_valid, 0);
    rdy_in = 1'b0;
    push(4'b0010, 32'h10, 32'h0, 12'h000, 4'd2, 1'b0, 4'd0);
    tick();
    chk("stall_count", dut.count, 0);
    chk("stall_valid", cache_valid, 0);
    rdy_in = 1'b1;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
